// File: rtl/life_pkg.sv
// Shared types and constants for the Game of Life generation sequencer:
// FSM states, the 3x3 neighbour walk order and the life rule thresholds.
package life_pkg;

  typedef enum logic [2:0] {
    IDLE,
    EDIT_RD,
    EDIT_WR,
    READ,
    LAST,
    WRITE,
    SWAP
  } state_e;

  localparam int NBR_N = 9;

  // Row-major walk from (-1,-1) to (+1,+1); entry 4 is the cell itself.
  localparam logic signed [1:0] NBR_DY [NBR_N] = '{
    -2'sd1, -2'sd1, -2'sd1,
     2'sd0,  2'sd0,  2'sd0,
     2'sd1,  2'sd1,  2'sd1
  };
  localparam logic signed [1:0] NBR_DX [NBR_N] = '{
    -2'sd1,  2'sd0,  2'sd1,
    -2'sd1,  2'sd0,  2'sd1,
    -2'sd1,  2'sd0,  2'sd1
  };

  localparam logic [3:0] SELF_K  = 4'd4;
  localparam logic [3:0] LAST_K  = 4'd8;

  localparam logic [3:0] BIRTH   = 4'd3;
  localparam logic [3:0] SURVIVE = 4'd2;

endpackage

// File: rtl/life_rule.sv
// Combinational life rule: next state of a cell from its live-neighbour
// count and its own current state.
module life_rule
  import life_pkg::*;
(
  input  logic [3:0] cnt,
  input  logic       self,
  output logic       next
);

  assign next = (cnt == BIRTH) | ((cnt == SURVIVE) & self);

endmodule

// File: rtl/life_gen_ctrl.sv
// Generation sequencer: walks every cell of the displayed bank, writes the
// next generation into the other bank, then swaps; also services cursor edits.
module life_gen_ctrl
  import life_pkg::*;
#(
  parameter int LOG2X = 3,
  parameter int LOG2Y = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   key_nxt,
  input  logic                   key_run,
  input  logic                   key_toggle,
  input  logic [LOG2X+LOG2Y-1:0] cur_cnt,
  output logic [LOG2X+LOG2Y:0]   rd_addr,
  input  logic                   rd_data,
  output logic                   wr_en,
  output logic [LOG2X+LOG2Y:0]   wr_addr,
  output logic                   wr_data,
  output logic                   bank,
  output logic                   busy,
  output logic                   gen_done,
  output logic [15:0]            gen_count
);

  localparam int A = LOG2X + LOG2Y;

  state_e         state_q, state_d;
  logic           bank_q, bank_d;
  logic [15:0]    gen_count_q, gen_count_d;
  logic           pend_q, pend_d;
  logic [A-1:0]   cell_q, cell_d;
  logic [3:0]     k_q, k_d;
  logic [3:0]     cnt_q, cnt_d;
  logic           self_q, self_d;
  logic           acc_vld_q, acc_vld_d;
  logic [3:0]     acc_k_q, acc_k_d;
  logic           key_nxt_q, key_tog_q;

  logic             nxt_rel, tog_rel, start;
  logic [LOG2Y-1:0] nbr_y;
  logic [LOG2X-1:0] nbr_x;
  logic             rule_next;

  assign nxt_rel = key_nxt_q & ~key_nxt;
  assign tog_rel = key_tog_q & ~key_toggle;

  // Torus wrap falls out of truncating the sign-extended offset sum.
  assign nbr_y = cell_q[A-1:LOG2X] + LOG2Y'(NBR_DY[k_q]);
  assign nbr_x = cell_q[LOG2X-1:0] + LOG2X'(NBR_DX[k_q]);

  life_rule u_rule (
    .cnt  (cnt_q),
    .self (self_q),
    .next (rule_next)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      bank_q      <= 1'b0;
      gen_count_q <= '0;
      pend_q      <= 1'b0;
      cell_q      <= '0;
      k_q         <= '0;
      cnt_q       <= '0;
      self_q      <= 1'b0;
      acc_vld_q   <= 1'b0;
      acc_k_q     <= '0;
      key_nxt_q   <= 1'b0;
      key_tog_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      bank_q      <= bank_d;
      gen_count_q <= gen_count_d;
      pend_q      <= pend_d;
      cell_q      <= cell_d;
      k_q         <= k_d;
      cnt_q       <= cnt_d;
      self_q      <= self_d;
      acc_vld_q   <= acc_vld_d;
      acc_k_q     <= acc_k_d;
      key_nxt_q   <= key_nxt;
      key_tog_q   <= key_toggle;
    end
  end

  always_comb begin
    state_d     = state_q;
    bank_d      = bank_q;
    gen_count_d = gen_count_q;
    pend_d      = pend_q;
    cell_d      = cell_q;
    k_d         = k_q;
    cnt_d       = cnt_q;
    self_d      = self_q;
    acc_vld_d   = 1'b0;
    acc_k_d     = k_q;
    start       = 1'b0;
    rd_addr     = '0;
    wr_en       = 1'b0;
    wr_addr     = '0;
    wr_data     = 1'b0;
    gen_done    = 1'b0;

    // Read data lags its address by a cycle, so accumulate the previous k.
    if (acc_vld_q) begin
      if (acc_k_q == SELF_K) self_d = rd_data;
      else                   cnt_d  = cnt_q + {3'b000, rd_data};
    end

    unique case (state_q)
      IDLE: begin
        if (tog_rel) begin
          state_d = EDIT_RD;
        end else if (pend_q | key_run) begin
          state_d = READ;
          cell_d  = '0;
          k_d     = '0;
          start   = 1'b1;
        end
      end
      EDIT_RD: begin
        rd_addr = {bank_q, cur_cnt};
        state_d = EDIT_WR;
      end
      EDIT_WR: begin
        wr_en   = 1'b1;
        wr_addr = {bank_q, cur_cnt};
        wr_data = ~rd_data;
        state_d = IDLE;
      end
      READ: begin
        rd_addr   = {bank_q, nbr_y, nbr_x};
        acc_vld_d = 1'b1;
        if (k_q == LAST_K) state_d = LAST;
        else               k_d     = k_q + 4'd1;
      end
      LAST: begin
        state_d = WRITE;
      end
      WRITE: begin
        wr_en   = 1'b1;
        wr_addr = {~bank_q, cell_q};
        wr_data = rule_next;
        cnt_d   = '0;
        if (&cell_q) begin
          state_d = SWAP;
        end else begin
          cell_d  = cell_q + A'(1);
          k_d     = '0;
          state_d = READ;
        end
      end
      SWAP: begin
        bank_d      = ~bank_q;
        gen_count_d = gen_count_q + 16'd1;
        gen_done    = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A release arriving in the start cycle must not be lost.
    if (start)   pend_d = 1'b0;
    if (nxt_rel) pend_d = 1'b1;
  end

  assign bank      = bank_q;
  assign busy      = (state_q != IDLE);
  assign gen_count = gen_count_q;

endmodule

// File: tb/tb_life_gen_ctrl.sv
// Scoreboard bench for life_gen_ctrl on an 8x8 board with a behavioural
// two-bank RAM; expected generation and edit events are queued up front.
module tb_life_gen_ctrl;

  localparam int LOG2X      = 3;
  localparam int LOG2Y      = 3;
  localparam int A          = LOG2X + LOG2Y;
  localparam int CELLS      = 1 << A;
  localparam int GEN_CYCLES = 705;

  localparam logic [CELLS-1:0] PAT_H    = (64'd1 << 26) | (64'd1 << 27) | (64'd1 << 28);
  localparam logic [CELLS-1:0] PAT_V    = (64'd1 << 19) | (64'd1 << 27) | (64'd1 << 35);
  localparam logic [CELLS-1:0] PAT_WIN  = (64'd1 << 7)  | (64'd1 << 0)  | (64'd1 << 1);
  localparam logic [CELLS-1:0] PAT_WOUT = (64'd1 << 56) | (64'd1 << 0)  | (64'd1 << 8);

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         key_nxt = 1'b0;
  logic         key_run = 1'b0;
  logic         key_toggle = 1'b0;
  logic [A-1:0] cur_cnt = '0;
  logic [A:0]   rd_addr;
  logic         rd_data;
  logic         wr_en;
  logic [A:0]   wr_addr;
  logic         wr_data;
  logic         bank;
  logic         busy;
  logic         gen_done;
  logic [15:0]  gen_count;

  life_gen_ctrl #(.LOG2X(LOG2X), .LOG2Y(LOG2Y)) dut (
    .clk        (clk),
    .reset      (reset),
    .key_nxt    (key_nxt),
    .key_run    (key_run),
    .key_toggle (key_toggle),
    .cur_cnt    (cur_cnt),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .bank       (bank),
    .busy       (busy),
    .gen_done   (gen_done),
    .gen_count  (gen_count)
  );

  always #5 clk = ~clk;

  // Behavioural board RAM; the bench can also overwrite a whole bank at once.
  logic             mem [2*CELLS];
  logic             load_en = 1'b0;
  logic             load_bank = 1'b0;
  logic [CELLS-1:0] load_pat = '0;

  always @(posedge clk) begin
    if (load_en) begin
      for (int i = 0; i < CELLS; i++) mem[{load_bank, A'(i)}] <= load_pat[i];
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    rd_data <= mem[rd_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        bank;
    logic [15:0] count;
  } gen_exp_t;

  typedef struct {
    logic [A:0] addr;
    logic       data;
    int         at_cyc;
  } edit_exp_t;

  gen_exp_t  gen_q[$];
  edit_exp_t edit_q[$];
  int checks = 0;
  int failures = 0;
  int busy_len = 0;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("[TB] FAIL %s: got event expected none", name);
  endtask

  function automatic logic [CELLS-1:0] bank_bits(input logic b);
    logic [CELLS-1:0] r;
    for (int i = 0; i < CELLS; i++) r[i] = mem[{b, A'(i)}];
    return r;
  endfunction

  task automatic monitor();
    gen_exp_t  ge;
    edit_exp_t ee;
    forever begin
      @(negedge clk);
      if (!reset) begin
        busy_len = 0;
      end else begin
        if (busy) busy_len++;
        if (gen_done) begin
          if (gen_q.size() == 0) begin
            fail_now("unexpected_gen_done");
          end else begin
            ge = gen_q.pop_front();
            check_output("gen_bank_before", 32'(bank), 32'(ge.bank));
            check_output("gen_count_before", 32'(gen_count), 32'(ge.count));
            check_output("gen_busy_cycles", busy_len, GEN_CYCLES);
          end
        end
        // Generation writes always target the hidden bank; displayed-bank writes are edits.
        if (wr_en && wr_addr[A] == bank) begin
          if (edit_q.size() == 0) begin
            fail_now("unexpected_edit_write");
          end else begin
            ee = edit_q.pop_front();
            check_output("edit_addr", 32'(wr_addr), 32'(ee.addr));
            check_output("edit_data", 32'(wr_data), 32'(ee.data));
            check_output("edit_cycle", cyc, ee.at_cyc);
          end
        end
        if (!busy) busy_len = 0;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus_load(input logic b, input logic [CELLS-1:0] pat);
    load_en   = 1'b1;
    load_bank = b;
    load_pat  = pat;
    tick();
    load_en   = 1'b0;
  endtask

  task automatic apply_stimulus_step();
    key_nxt = 1'b1;
    tick();
    key_nxt = 1'b0;
  endtask

  task automatic apply_stimulus_reset();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic wait_busy(input int max);
    int n = 0;
    @(negedge clk);
    while (!busy && n < max) begin
      @(negedge clk);
      n++;
    end
    if (!busy) fail_now("busy_rise_timeout");
  endtask

  task automatic wait_idle(input int max);
    int n = 0;
    @(negedge clk);
    while (busy && n < max) begin
      @(negedge clk);
      n++;
    end
    if (busy) fail_now("idle_timeout");
  endtask

  initial begin
    edit_exp_t ee;
    int        rel_cyc;

    fork
      monitor();
    join_none

    // Reset held with random inputs.
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      key_nxt    = 1'($urandom_range(0, 1));
      key_run    = 1'($urandom_range(0, 1));
      key_toggle = 1'($urandom_range(0, 1));
      cur_cnt    = A'($urandom_range(0, CELLS - 1));
      tick();
    end
    @(negedge clk);
    check_output("rst_busy", 32'(busy), 0);
    check_output("rst_gen_done", 32'(gen_done), 0);
    check_output("rst_wr_en", 32'(wr_en), 0);
    check_output("rst_rd_addr", 32'(rd_addr), 0);
    check_output("rst_wr_addr", 32'(wr_addr), 0);
    check_output("rst_wr_data", 32'(wr_data), 0);
    check_output("rst_bank", 32'(bank), 0);
    check_output("rst_gen_count", 32'(gen_count), 0);
    key_nxt = 1'b0;
    key_run = 1'b0;
    key_toggle = 1'b0;
    cur_cnt = '0;
    tick();
    reset = 1'b1;
    repeat (5) tick();
    check_output("post_rst_busy", 32'(busy), 0);

    // Cursor edit in IDLE.
    apply_stimulus_load(1'b0, '0);
    apply_stimulus_load(1'b1, '0);
    cur_cnt = {3'd2, 3'd5};
    key_toggle = 1'b1;
    tick();
    key_toggle = 1'b0;
    rel_cyc = cyc;
    ee.addr = {1'b0, 3'd2, 3'd5};
    ee.data = 1'b1;
    ee.at_cyc = rel_cyc + 2;
    edit_q.push_back(ee);
    repeat (5) tick();
    check_output("edit_mem_cell", 32'(mem[{1'b0, 3'd2, 3'd5}]), 1);
    check_output("edit_done_busy", 32'(busy), 0);

    // Blinker single step, with a toggle release while busy that must be dropped.
    apply_stimulus_load(1'b0, PAT_H);
    apply_stimulus_load(1'b1, '0);
    gen_q.push_back('{bank: 1'b0, count: 16'd0});
    apply_stimulus_step();
    wait_busy(5);
    repeat (50) tick();
    key_toggle = 1'b1;
    tick();
    key_toggle = 1'b0;
    wait_idle(1000);
    repeat (3) tick();
    check_output("blinker_bank", 32'(bank), 1);
    check_output("blinker_count", 32'(gen_count), 1);
    check_output("blinker_b1_lo", bank_bits(1'b1)[31:0], PAT_V[31:0]);
    check_output("blinker_b1_hi", bank_bits(1'b1)[63:32], PAT_V[63:32]);

    // Torus wrap.
    apply_stimulus_reset();
    apply_stimulus_load(1'b0, PAT_WIN);
    apply_stimulus_load(1'b1, '0);
    gen_q.push_back('{bank: 1'b0, count: 16'd0});
    apply_stimulus_step();
    wait_busy(5);
    wait_idle(1000);
    repeat (3) tick();
    check_output("wrap_count", 32'(gen_count), 1);
    check_output("wrap_b1_lo", bank_bits(1'b1)[31:0], PAT_WOUT[31:0]);
    check_output("wrap_b1_hi", bank_bits(1'b1)[63:32], PAT_WOUT[63:32]);

    // Run for three generations.
    apply_stimulus_reset();
    apply_stimulus_load(1'b0, PAT_H);
    apply_stimulus_load(1'b1, '0);
    gen_q.push_back('{bank: 1'b0, count: 16'd0});
    gen_q.push_back('{bank: 1'b1, count: 16'd1});
    gen_q.push_back('{bank: 1'b0, count: 16'd2});
    key_run = 1'b1;
    begin
      int n = 0;
      @(negedge clk);
      while (!(gen_count == 16'd2 && busy) && n < 3000) begin
        @(negedge clk);
        n++;
      end
      if (!(gen_count == 16'd2 && busy)) fail_now("run_third_gen_timeout");
    end
    key_run = 1'b0;
    wait_idle(1000);
    repeat (5) tick();
    check_output("run_count", 32'(gen_count), 3);
    check_output("run_bank", 32'(bank), 1);
    check_output("run_b1_lo", bank_bits(1'b1)[31:0], PAT_V[31:0]);
    check_output("run_b1_hi", bank_bits(1'b1)[63:32], PAT_V[63:32]);
    check_output("run_b0_lo", bank_bits(1'b0)[31:0], PAT_H[31:0]);
    check_output("run_b0_hi", bank_bits(1'b0)[63:32], PAT_H[63:32]);

    // Step released again mid-generation latches exactly one more generation.
    gen_q.push_back('{bank: 1'b1, count: 16'd3});
    gen_q.push_back('{bank: 1'b0, count: 16'd4});
    apply_stimulus_step();
    wait_busy(5);
    repeat (100) tick();
    apply_stimulus_step();
    wait_idle(1000);
    repeat (3) tick();
    wait_idle(1000);
    repeat (20) tick();
    check_output("latch_busy", 32'(busy), 0);
    check_output("latch_count", 32'(gen_count), 5);
    check_output("latch_bank", 32'(bank), 1);
    check_output("latch_b1_lo", bank_bits(1'b1)[31:0], PAT_V[31:0]);

    // Reset mid-generation.
    apply_stimulus_reset();
    apply_stimulus_load(1'b0, PAT_H);
    apply_stimulus_load(1'b1, '0);
    apply_stimulus_step();
    wait_busy(5);
    repeat (300) tick();
    reset = 1'b0;
    #1;
    check_output("midrst_busy", 32'(busy), 0);
    check_output("midrst_bank", 32'(bank), 0);
    check_output("midrst_count", 32'(gen_count), 0);
    tick();
    reset = 1'b1;
    repeat (3) tick();
    check_output("midrst_idle", 32'(busy), 0);
    check_output("midrst_b0_lo", bank_bits(1'b0)[31:0], PAT_H[31:0]);
    check_output("midrst_b0_hi", bank_bits(1'b0)[63:32], PAT_H[63:32]);

    check_output("gen_queue_drained", gen_q.size(), 0);
    check_output("edit_queue_drained", edit_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/life_gen_ctrl.md
# life_gen_ctrl

Generation sequencer for the Game of Life board. It owns the read and write ports of a two-bank, 1-bit-per-cell board RAM and computes one full generation from the current bank into the other bank. It then swaps banks. It also arbitrates the same ports for single-cell edits at the cursor position, and sits between the key/cursor front end and the board RAM.

## Interface

- `LOG2X`, default 3: board width is 2^LOG2X cells.
- `LOG2Y`, default 3: board height is 2^LOG2Y cells.
- Localparam `A = LOG2X+LOG2Y`: cell address width.

- `clk`  in  1: sole clock.
- `reset`  in  1: asynchronous, active-low.
- `key_nxt`  in  1: step key, level. Its release (falling edge) requests one generation.
- `key_run`  in  1: level. While high, generations run back-to-back.
- `key_toggle`  in  1: level. Its release requests an inversion of the cell at the cursor.
- `cur_cnt`  in  A: cursor cell, laid out as {y, x}.
- `rd_addr`  out  A+1: RAM read address, laid out as {bank, y, x}.
- `rd_data`  in  1: RAM read data, valid exactly one cycle after `rd_addr`.
- `wr_en`  out  1: RAM write strobe.
- `wr_addr`  out  A+1: RAM write address.
- `wr_data`  out  1: RAM write data.
- `bank`  out  1: bank holding the current (displayed) generation.
- `busy`  out  1: high in any state other than IDLE.
- `gen_done`  out  1: one-cycle pulse when the bank swaps.
- `gen_count`  out  16: number of completed generations; wraps from 0xFFFF to 0.

## Operation

- Keys are registered each cycle (`key_*_d`). Release = `key_*_d & !key_*`.
- A `key_nxt` release sets `pend`, whether or not the block is busy. `pend` is cleared when a generation starts.
- A `key_toggle` release is honoured only in IDLE. While busy it is dropped.
- FSM states: IDLE, EDIT_RD, EDIT_WR, READ, LAST, WRITE, SWAP.
- IDLE priority, highest first:
  1. toggle release → EDIT_RD.
  2. `pend` or `key_run` → READ, with cell = 0 and k = 0.
- EDIT_RD: `rd_addr = {bank, cur_cnt}`. Next state EDIT_WR.
- EDIT_WR: `wr_en = 1`, `wr_addr = {bank, cur_cnt}`, `wr_data = !rd_data`. Next state IDLE.
- READ: k counts 0..8 over neighbour offsets (dy,dx), row-major from (-1,-1) to (+1,+1). k = 4 is the cell itself.
  - `rd_addr = {bank, y+dy, x+dx}`, computed modulo 2^LOG2Y and 2^LOG2X; the torus wrap comes from width truncation.
  - The returned data is accumulated one cycle later: the count is 4 bits wide and excludes k = 4, which is captured as `self` instead.
  - After k = 8 is issued, go to LAST.
- LAST: capture the final `rd_data` (k = 8). Go to WRITE.
- WRITE: `wr_en = 1`, `wr_addr = {!bank, cell}`, `wr_data = (cnt==3) | (cnt==2 & self)`.
  - Clear the count.
  - If cell is all-ones, go to SWAP. Otherwise increment cell and go to READ with k = 0.
- SWAP: `bank <= !bank`, `gen_count++`, `gen_done = 1`. Go to IDLE.
- The write bank is never the displayed bank during a generation. An external display may read `bank` at any time.
- `key_run` falling mid-generation has no effect; the current generation completes.

## Timing

- Reset values: `bank = 0`, `gen_count = 0`, `busy = 0`, `gen_done = 0`, `wr_en = 0`, `rd_addr = 0`, `wr_addr = 0`, `wr_data = 0`; `pend` cleared; state IDLE.
- RAM contents are not touched by reset.
- Release is detected in the cycle the key is low and `key_*_d` is high. The FSM leaves IDLE on the following clock edge.
- Edit takes 2 cycles after leaving IDLE, with the write in the second cycle.
- Each cell takes 11 cycles: READ ×9, LAST, WRITE.
- One generation takes 11·2^A + 1 cycles of `busy`; for 8×8 that is 705. `gen_done` is asserted in the last of those cycles.
- With `key_run` held, one IDLE cycle separates consecutive generations.
- Reset asserted mid-operation aborts immediately to the reset values. The partially written inactive bank is left as is.

## Structure

- Shared package `life_pkg` holds:
  - the FSM state enum;
  - the 9-entry neighbour offset table (dy, dx as 2-bit signed values);
  - the rule constants BIRTH = 3 and SURVIVE = 2.
- One combinational sub-module, `life_rule` (inputs cnt[3:0] and self; output next), keeps the rule swappable.
- Address arithmetic and the FSM stay in `life_gen_ctrl`.

## Test plan

- **Reset:** hold `reset = 0` with random inputs → all outputs 0, state IDLE. Release reset with no keys → `busy` stays 0.
- **Blinker (8×8 behavioural RAM):** bank 0 cells (y3,x2), (y3,x3), (y3,x4). Pulse `key_nxt` → `gen_done` 705 cycles after `busy` rises. Then `bank = 1`, `gen_count = 1`, and bank 1 holds exactly (y2,x3), (y3,x3), (y4,x3).
- **Wrap:** bank 0 cells (y0,x7), (y0,x0), (y0,x1), then step → bank 1 holds exactly (y7,x0), (y0,x0), (y1,x0).
- **Edit:** `cur_cnt = {3'd2, 3'd5}` with the cell at 0, release `key_toggle` in IDLE → one write with `wr_addr = {0,2,5}`, `wr_data = 1`, 2 cycles later. A toggle released while busy produces no edit write.
- **Run and latch:** hold `key_run` for 3 generations → `gen_count = 3`, `bank` reads 1, 0, 1 in turn, blinker alternates. Release `key_nxt` mid-generation with `key_run` low → exactly one further generation.
- **Reset mid-generation:** assert reset at cycle 300 of a step → `busy = 0`, `bank = 0`, `gen_count` unchanged at 0. Bank 0 contents are intact.
